// File: rtl/slot_packer.sv
// Sequential M-bit to N*M-bit slot packer with valid/ready on both sides and a per-slot keep mask.
// Define SLOT_PACK_ADDR_EN to add the i_sel port for addressed (random-order) slot writes.
module slot_packer #(
  parameter int N = 8,
  parameter int M = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [M-1:0]   i_data,
  input  logic           i_last,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [N*M-1:0] o_data,
  output logic [N-1:0]   o_keep
`ifdef SLOT_PACK_ADDR_EN
  ,
  input  logic [SW-1:0]  i_sel
`endif
);

  logic [N*M-1:0] fill_data;
  logic [N-1:0]   fill_keep;
  logic [N*M-1:0] merged_data;
  logic [N-1:0]   merged_keep;
  logic [SW-1:0]  wr_idx;
  logic           wr_en;
  logic           accept;
  logic           close;
`ifndef SLOT_PACK_ADDR_EN
  logic [SW-1:0]  cnt;
`endif

  assign o_ready = ~o_valid | i_ready;
  assign accept  = i_valid & o_ready;

  // Target slot selection: running counter, or caller-supplied index with out-of-range drop.
  always_comb begin
`ifdef SLOT_PACK_ADDR_EN
    wr_idx = i_sel;
    wr_en  = (32'(i_sel) < 32'(N));
`else
    wr_idx = cnt;
    wr_en  = 1'b1;
`endif
  end

  // Fill buffer as it would look with this beat written in.
  always_comb begin
    merged_data = fill_data;
    merged_keep = fill_keep;
    if (wr_en) begin
      merged_data[wr_idx*M +: M] = i_data;
      merged_keep[wr_idx]        = 1'b1;
    end else begin
      merged_data = fill_data;
      merged_keep = fill_keep;
    end
  end

  // A beat closes the word on i_last or when it completes the last empty slot.
  always_comb begin
`ifdef SLOT_PACK_ADDR_EN
    close = accept & (i_last | (&merged_keep));
`else
    close = accept & (i_last | (cnt == SW'(N - 1)));
`endif
  end

  // Fill buffer and output register; a close and a drain in the same cycle keep o_valid high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_data    <= {(N*M){1'b0}};
      o_keep    <= {N{1'b0}};
      fill_data <= {(N*M){1'b0}};
      fill_keep <= {N{1'b0}};
`ifndef SLOT_PACK_ADDR_EN
      cnt       <= {SW{1'b0}};
`endif
    end else begin
      if (close) begin
        o_data  <= merged_data;
        o_keep  <= merged_keep;
        o_valid <= 1'b1;
      end else if (o_valid & i_ready) begin
        o_valid <= 1'b0;
      end else begin
        o_valid <= o_valid;
      end

      if (close) begin
        fill_data <= {(N*M){1'b0}};
        fill_keep <= {N{1'b0}};
`ifndef SLOT_PACK_ADDR_EN
        cnt       <= {SW{1'b0}};
`endif
      end else if (accept) begin
        fill_data <= merged_data;
        fill_keep <= merged_keep;
`ifndef SLOT_PACK_ADDR_EN
        cnt       <= cnt + SW'(1);
`endif
      end else begin
        fill_data <= fill_data;
        fill_keep <= fill_keep;
      end
    end
  end

endmodule

// File: tb/tb_slot_packer.sv
// Directed self-checking bench for slot_packer at N=4, M=8.
// With SLOT_PACK_ADDR_EN defined only the reset and addressed-write scenarios run.
module tb_slot_packer;

  localparam int N = 4;
  localparam int M = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [M-1:0]  i_data = 8'h00;
  logic          i_last = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [N*M-1:0] o_data;
  logic [N-1:0]  o_keep;
`ifdef SLOT_PACK_ADDR_EN
  logic [1:0]    i_sel = 2'd0;
`endif

  int checks = 0;
  int errors = 0;

  slot_packer #(.N(N), .M(M)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_keep  (o_keep)
`ifdef SLOT_PACK_ADDR_EN
    ,
    .i_sel   (i_sel)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic test_reset();
    i_ready = 1'b0;
    i_rst   = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", o_data); end
    checks++; if (o_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %b want 0000", o_keep); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
  endtask

`ifndef SLOT_PACK_ADDR_EN
  task automatic test_full_word();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = vals[i]; i_last = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d]: got %b want 1", i, o_ready); end
      if (i == 3) begin
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b want 0", o_valid); end
      end
      tick();
    end
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== 32'h44332211) begin errors++; $display("FAIL full_data: got %h want 44332211", o_data); end
    checks++; if (o_keep !== 4'b1111) begin errors++; $display("FAIL full_keep: got %b want 1111", o_keep); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== 32'h44332211) begin errors++; $display("FAIL drain_hold: got %h want 44332211", o_data); end
  endtask

  task automatic test_partial();
    i_ready = 1'b1;
    drive_beat(8'hA1, 1'b0);
    drive_beat(8'hA2, 1'b1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL partial_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== 32'h0000A2A1) begin errors++; $display("FAIL partial_data: got %h want 0000a2a1", o_data); end
    checks++; if (o_keep !== 4'b0011) begin errors++; $display("FAIL partial_keep: got %b want 0011", o_keep); end
    tick();
  endtask

  task automatic test_stall();
    i_ready = 1'b0;
    drive_beat(8'h10, 1'b0);
    drive_beat(8'h20, 1'b0);
    drive_beat(8'h30, 1'b0);
    drive_beat(8'h40, 1'b0);
    checks++; if (o_data !== 32'h40302010) begin errors++; $display("FAIL stall_word: got %h want 40302010", o_data); end
    i_valid = 1'b1; i_data = 8'h55; i_last = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", o_ready); end
    tick();
    tick();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== 32'h40302010) begin errors++; $display("FAIL stall_hold: got %h want 40302010", o_data); end
    checks++; if (o_keep !== 4'b1111) begin errors++; $display("FAIL stall_keep: got %b want 1111", o_keep); end
    i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", o_ready); end
    tick();
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %b want 0", o_valid); end
    drive_beat(8'h66, 1'b0);
    drive_beat(8'h77, 1'b0);
    drive_beat(8'h88, 1'b0);
    checks++; if (o_data !== 32'h88776655) begin errors++; $display("FAIL stall_next: got %h want 88776655", o_data); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid: got %b want 1", o_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      i_valid = 1'b1; i_data = 8'(i); i_last = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, o_ready); end
      tick();
      if (i == 4) begin
        checks++; if (o_data !== 32'h04030201) begin errors++; $display("FAIL b2b_word0: got %h want 04030201", o_data); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0: got %b want 1", o_valid); end
      end
      if (i == 5) begin
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", o_valid); end
      end
    end
    checks++; if (o_data !== 32'h08070605) begin errors++; $display("FAIL b2b_word1: got %h want 08070605", o_data); end
    checks++; if (o_keep !== 4'b1111) begin errors++; $display("FAIL b2b_keep1: got %b want 1111", o_keep); end
    // Each beat closes while the previous word drains: o_valid must stay high.
    drive_beat(8'hE1, 1'b1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL last_first_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== 32'h000000E1) begin errors++; $display("FAIL last_first_data: got %h want 000000e1", o_data); end
    checks++; if (o_keep !== 4'b0001) begin errors++; $display("FAIL last_first_keep: got %b want 0001", o_keep); end
    drive_beat(8'hE2, 1'b1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL close_drain_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== 32'h000000E2) begin errors++; $display("FAIL close_drain_data: got %h want 000000e2", o_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    drive_beat(8'h91, 1'b0);
    drive_beat(8'h92, 1'b0);
    i_rst = 1'b1; i_valid = 1'b1; i_data = 8'h93; i_last = 1'b1;
    tick();
    i_rst = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 00000000", o_data); end
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h02, 1'b0);
    drive_beat(8'h03, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_partial: got %b want 0", o_valid); end
    drive_beat(8'h04, 1'b0);
    checks++; if (o_data !== 32'h04030201) begin errors++; $display("FAIL rst_mid_word: got %h want 04030201", o_data); end
    checks++; if (o_keep !== 4'b1111) begin errors++; $display("FAIL rst_mid_keep: got %b want 1111", o_keep); end
    tick();
  endtask
`else
  task automatic test_addr();
    i_ready = 1'b1;
    i_sel = 2'd3; drive_beat(8'hDD, 1'b0);
    i_sel = 2'd1; drive_beat(8'hBB, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL addr_early_valid: got %b want 0", o_valid); end
    i_sel = 2'd0; drive_beat(8'hAA, 1'b1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL addr_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== 32'hDD00BBAA) begin errors++; $display("FAIL addr_data: got %h want dd00bbaa", o_data); end
    checks++; if (o_keep !== 4'b1011) begin errors++; $display("FAIL addr_keep: got %b want 1011", o_keep); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifndef SLOT_PACK_ADDR_EN
    test_full_word();
    test_partial();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`else
    test_addr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
